// File: rtl/fw_pkg.sv
// Shared definitions for the blocked Floyd-Warshall tile scheduler:
// phase encodings, scheduler FSM states and tile geometry defaults.
package fw_pkg;

   // fw phase select encodings
   localparam logic [1:0] PH_SELF = 2'b00;
   localparam logic [1:0] PH_ROW  = 2'b01;
   localparam logic [1:0] PH_COL  = 2'b10;
   localparam logic [1:0] PH_DBL  = 2'b11;

   // 8 rows x 2 words of 64 bits per 8x8 tile
   localparam int FW_WORDS_PER_TILE = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } fw_state_e;

   // Width of a block index; a one-tile matrix still needs a 1-bit port.
   function automatic int idx_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/fw_retire_cnt.sv
// Counts fw output words modulo WORDS_PER_TILE and pulses retire on the
// last word of each tile. Words arriving while disabled (nothing in
// flight) are dropped and do not advance the count.
module fw_retire_cnt
   import fw_pkg::*;
#(
   parameter int WORDS_PER_TILE = FW_WORDS_PER_TILE
)(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic out_valid,
   output logic retire
);

   localparam int            CW     = (WORDS_PER_TILE > 1) ? $clog2(WORDS_PER_TILE) : 1;
   localparam int            LAST_I = WORDS_PER_TILE - 1;
   localparam logic [CW-1:0] LAST   = CW'(LAST_I);

   logic [CW-1:0] word_cnt;
   logic          count_en;

   assign count_en = out_valid & en;
   assign retire   = count_en && (word_cnt == LAST);

   // word counter, wraps to zero on the tile's last word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt <= '0;
      end else if (retire) begin
         word_cnt <= '0;
      end else if (count_en) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fw_tile_sched.sv
// Tile scheduler for blocked Floyd-Warshall. For each pivot block k it
// issues the self, row, column and doubly-dependent tiles in order, holds
// a barrier between phases until every issued tile has retired, and caps
// the number of tiles in flight at MAX_OUT.
module fw_tile_sched
   import fw_pkg::*;
#(
   parameter int  NB             = 4,
   parameter int  WORDS_PER_TILE = FW_WORDS_PER_TILE,
   parameter int  MAX_OUT        = 2,
   localparam int IW             = idx_width(NB)
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [1:0]    phase,
   output logic          tile_valid,
   input  logic          tile_ready,
   output logic [IW-1:0] tile_i,
   output logic [IW-1:0] tile_j,
   output logic [IW-1:0] tile_k,
   input  logic          inhibit,
   input  logic          out_valid
);

   localparam int            OW      = $clog2(MAX_OUT + 1);
   localparam logic [OW-1:0] MAX_X   = OW'(MAX_OUT);
   localparam logic [IW:0]   NB_X    = (IW + 1)'(NB);
   localparam logic [IW-1:0] K_LAST  = IW'(NB - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);

   fw_state_e     state_q, state_d;
   logic [1:0]    ph_q, ph_d;
   logic [IW-1:0] ti_q, ti_d;
   logic [IW-1:0] tj_q, tj_d;
   logic [IW-1:0] tk_q, tk_d;
   logic          tv_q, tv_d;
   logic [OW-1:0] outst_q, outst_d;

   logic          accept;
   logic          retire;
   logic          can_raise;
   logic          last_tile;
   logic [IW-1:0] first_nk;
   logic [IW:0]   ni_x;
   logic [IW:0]   nj_x;

   // Next block index after x, stepping over the pivot k. The extra bit
   // lets the caller see running off the end of the row/column.
   function automatic logic [IW:0] next_skip(input logic [IW-1:0] x,
                                             input logic [IW-1:0] k);
      logic [IW:0] n;
      n = {1'b0, x} + 1'b1;
      if (n == {1'b0, k}) begin
         n = n + 1'b1;
      end
      return n;
   endfunction

   assign accept   = tv_q & tile_ready;
   assign first_nk = (tk_q == '0) ? IDX_ONE : '0;
   assign ni_x     = next_skip(ti_q, tk_q);
   assign nj_x     = next_skip(tj_q, tk_q);

   fw_retire_cnt #(
      .WORDS_PER_TILE (WORDS_PER_TILE)
   ) u_retire (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (outst_q != '0),
      .out_valid (out_valid),
      .retire    (retire)
   );

   // in-flight count: accept adds one, retire removes one, both cancel
   always_comb begin
      outst_d = outst_q;
      if (accept && !retire) begin
         outst_d = outst_q + 1'b1;
      end else if (!accept && retire) begin
         outst_d = outst_q - 1'b1;
      end
   end

   // a new descriptor may only be raised with room in the pipeline
   assign can_raise = (outst_d < MAX_X) && !inhibit;

   // next-state, index walk and descriptor-valid generation
   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      ti_d      = ti_q;
      tj_d      = tj_q;
      tk_d      = tk_q;
      tv_d      = tv_q && !accept;
      last_tile = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               ph_d    = PH_SELF;
               ti_d    = '0;
               tj_d    = '0;
               tk_d    = '0;
               tv_d    = !inhibit;
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               case (ph_q)
                  PH_SELF: last_tile = 1'b1;
                  PH_ROW: begin
                     if (nj_x >= NB_X) last_tile = 1'b1;
                     else              tj_d      = nj_x[IW-1:0];
                  end
                  PH_COL: begin
                     if (ni_x >= NB_X) last_tile = 1'b1;
                     else              ti_d      = ni_x[IW-1:0];
                  end
                  default: begin
                     if (nj_x < NB_X) begin
                        tj_d = nj_x[IW-1:0];
                     end else if (ni_x < NB_X) begin
                        ti_d = ni_x[IW-1:0];
                        tj_d = first_nk;
                     end else begin
                        last_tile = 1'b1;
                     end
                  end
               endcase
               if (last_tile) begin
                  state_d = ST_DRAIN;
                  tv_d    = 1'b0;
               end else begin
                  tv_d    = can_raise;
               end
            end else if (!tv_q) begin
               tv_d = can_raise;
            end
         end
         ST_DRAIN: begin
            if (outst_q == '0) begin
               state_d = ST_ISSUE;
               tv_d    = !inhibit;
               if (ph_q == PH_DBL || NB == 1) begin
                  if (tk_q == K_LAST) begin
                     state_d = ST_FIN;
                     tv_d    = 1'b0;
                  end else begin
                     ph_d = PH_SELF;
                     tk_d = tk_q + IDX_ONE;
                     ti_d = tk_q + IDX_ONE;
                     tj_d = tk_q + IDX_ONE;
                  end
               end else begin
                  ph_d = ph_q + 2'd1;
                  case (ph_q)
                     PH_SELF: begin
                        ti_d = tk_q;
                        tj_d = first_nk;
                     end
                     PH_ROW: begin
                        ti_d = first_nk;
                        tj_d = tk_q;
                     end
                     default: begin
                        ti_d = first_nk;
                        tj_d = first_nk;
                     end
                  endcase
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            tv_d    = 1'b0;
         end
      endcase
   end

   // scheduler state, descriptor and in-flight registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ph_q    <= PH_SELF;
         ti_q    <= '0;
         tj_q    <= '0;
         tk_q    <= '0;
         tv_q    <= 1'b0;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         ti_q    <= ti_d;
         tj_q    <= tj_d;
         tk_q    <= tk_d;
         tv_q    <= tv_d;
         outst_q <= outst_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign phase      = ph_q;
   assign tile_valid = tv_q;
   assign tile_i     = ti_q;
   assign tile_j     = tj_q;
   assign tile_k     = tk_q;

endmodule

// File: tb/tb_fw_tile_sched.sv
// Directed bench for fw_tile_sched: three instances (NB = 1, 2, 4) driven
// from one linear sequence, with a simple fw responder that returns 16
// words per accepted tile after a fixed delay.
module tb_fw_tile_sched;

   logic       clk;
   logic       rst_n;
   logic       st [3];
   logic       tr [3];
   logic       inh [3];
   logic       man [3];
   logic       man_ov [3];
   logic       ov_m [3];
   logic       ov [3];
   logic       tv [3];
   logic       bsy [3];
   logic       dn [3];
   logic [1:0] ph [3];
   logic [1:0] di [3];
   logic [1:0] dj [3];
   logic [1:0] dk [3];
   logic [0:0] i1, j1, k1, i2, j2, k2;
   logic [1:0] i4, j4, k4;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int dly  = 20;
   int out_b [3], wc_b [3], out_last [3], max_out [3], viol [3];
   int ph_nz [3], done_cnt [3], done_cyc [3], last_ov [3];
   int owed [3], cd [3], wc_m [3];
   logic [1:0] ph_last [3];
   logic [7:0] lg0 [$];
   logic [7:0] lg1 [$];
   logic [7:0] lg2 [$];

   // expected NB=2 order, packed {phase, i, j, k}
   logic [7:0] exp2 [8] = '{8'b00_00_00_00, 8'b01_00_01_00, 8'b10_01_00_00, 8'b11_01_01_00,
                            8'b00_01_01_01, 8'b01_01_00_01, 8'b10_00_01_01, 8'b11_00_00_01};

   fw_tile_sched #(.NB(1), .WORDS_PER_TILE(16), .MAX_OUT(2)) u_d1 (
      .clk(clk), .reset_n(rst_n), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
      .phase(ph[0]), .tile_valid(tv[0]), .tile_ready(tr[0]), .tile_i(i1),
      .tile_j(j1), .tile_k(k1), .inhibit(inh[0]), .out_valid(ov[0]));

   fw_tile_sched #(.NB(2), .WORDS_PER_TILE(16), .MAX_OUT(2)) u_d2 (
      .clk(clk), .reset_n(rst_n), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
      .phase(ph[1]), .tile_valid(tv[1]), .tile_ready(tr[1]), .tile_i(i2),
      .tile_j(j2), .tile_k(k2), .inhibit(inh[1]), .out_valid(ov[1]));

   fw_tile_sched #(.NB(4), .WORDS_PER_TILE(16), .MAX_OUT(2)) u_d4 (
      .clk(clk), .reset_n(rst_n), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
      .phase(ph[2]), .tile_valid(tv[2]), .tile_ready(tr[2]), .tile_i(i4),
      .tile_j(j4), .tile_k(k4), .inhibit(inh[2]), .out_valid(ov[2]));

   assign di[0] = {1'b0, i1};
   assign dj[0] = {1'b0, j1};
   assign dk[0] = {1'b0, k1};
   assign di[1] = {1'b0, i2};
   assign dj[1] = {1'b0, j2};
   assign dk[1] = {1'b0, k2};
   assign di[2] = i4;
   assign dj[2] = j4;
   assign dk[2] = k4;
   assign ov[0] = man[0] ? man_ov[0] : ov_m[0];
   assign ov[1] = man[1] ? man_ov[1] : ov_m[1];
   assign ov[2] = man[2] ? man_ov[2] : ov_m[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fw responder: per accepted tile, wait dly cycles then stream 16 words
   always @(posedge clk) begin
      for (int m = 0; m < 3; m++) begin
         if (!rst_n) begin
            owed[m] = 0;
            cd[m]   = 0;
            wc_m[m] = 0;
            ov_m[m] <= 1'b0;
         end else begin
            if (tv[m] && tr[m]) owed[m]++;
            ov_m[m] <= 1'b0;
            if (owed[m] > 0) begin
               if (cd[m] < dly) begin
                  cd[m]++;
               end else begin
                  ov_m[m] <= 1'b1;
                  wc_m[m]++;
                  if (wc_m[m] == 16) begin
                     wc_m[m] = 0;
                     cd[m]   = 0;
                     owed[m]--;
                  end
               end
            end
         end
      end
   end

   // observer: accepted-descriptor log, in-flight tracking, done timing
   always @(posedge clk) begin
      logic       a, r;
      logic [7:0] d;
      for (int m = 0; m < 3; m++) begin
         if (!rst_n) begin
            out_b[m] = 0; wc_b[m] = 0; out_last[m] = 0; max_out[m] = 0;
            viol[m] = 0; ph_nz[m] = 0; done_cnt[m] = 0; done_cyc[m] = 0;
            last_ov[m] = 0; ph_last[m] = 2'b00;
            if (m == 0) lg0.delete();
            else if (m == 1) lg1.delete();
            else lg2.delete();
         end else begin
            if (ph[m] != ph_last[m] && out_last[m] != 0) viol[m]++;
            ph_last[m]  = ph[m];
            out_last[m] = out_b[m];
            if (ph[m] != 2'b00) ph_nz[m]++;
            if (dn[m]) begin
               done_cnt[m]++;
               done_cyc[m] = cyc;
            end
            if (ov[m]) last_ov[m] = cyc;
            r = 1'b0;
            if (ov[m] && out_b[m] > 0) begin
               if (wc_b[m] == 15) begin
                  wc_b[m] = 0;
                  r = 1'b1;
               end else begin
                  wc_b[m]++;
               end
            end
            a = tv[m] && tr[m];
            if (a) begin
               d = {ph[m], di[m], dj[m], dk[m]};
               if (m == 0) lg0.push_back(d);
               else if (m == 1) lg1.push_back(d);
               else lg2.push_back(d);
            end
            out_b[m] = out_b[m] + int'(a) - int'(r);
            if (out_b[m] > max_out[m]) max_out[m] = out_b[m];
         end
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      nvec++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, o, e);
      end
   endtask

   function automatic logic [7:0] dsc(input int m);
      return {ph[m], di[m], dj[m], dk[m]};
   endfunction

   task automatic words(input int m, input int n);
      for (int w = 0; w < n; w++) begin
         man_ov[m] = 1'b1;
         @(negedge clk);
      end
      man_ov[m] = 1'b0;
   endtask

   initial begin
      logic ok;
      rst_n = 1'b0;
      for (int m = 0; m < 3; m++) begin
         st[m] = 1'b0; tr[m] = 1'b0; inh[m] = 1'b0; man[m] = 1'b0; man_ov[m] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bsy[1]), 0);
      check("rst_done", 32'(dn[1]), 0);
      check("rst_valid", 32'(tv[1]), 0);
      check("rst_desc", 32'(dsc(1)), 0);
      check("rst_desc_nb4", 32'(dsc(2)), 0);
      rst_n = 1'b1;

      // full solves on all three instances, ready tied high
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
         tr[m] = 1'b1;
         st[m] = 1'b1;
      end
      @(negedge clk);
      for (int m = 0; m < 3; m++) st[m] = 1'b0;
      check("start_busy_nb2", 32'(bsy[1]), 1);
      check("start_valid_nb2", 32'(tv[1]), 1);
      check("start_valid_nb1", 32'(tv[0]), 1);
      check("start_valid_nb4", 32'(tv[2]), 1);
      check("start_desc_nb4", 32'(dsc(2)), 0);
      ok = 1'b0;
      for (int g = 0; g < 8000 && !ok; g++) begin
         @(negedge clk);
         ok = done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0 && !bsy[0] && !bsy[1] && !bsy[2];
      end
      check("run1_complete", 32'(ok), 1);
      check("nb2_count", 32'(lg1.size()), 8);
      for (int n = 0; n < 8; n++)
         check($sformatf("nb2_order[%0d]", n), 32'((n < lg1.size()) ? lg1[n] : 8'hxx), 32'(exp2[n]));
      check("nb2_done_cnt", 32'(done_cnt[1]), 1);
      check("nb2_busy_after", 32'(bsy[1]), 0);
      check("nb1_count", 32'(lg0.size()), 1);
      check("nb1_desc", 32'((lg0.size() > 0) ? lg0[0] : 8'hxx), 0);
      check("nb1_done_lag", 32'(done_cyc[0] - last_ov[0]), 2);
      check("nb1_phase_nz", 32'(ph_nz[0]), 0);
      check("nb1_done_cnt", 32'(done_cnt[0]), 1);
      check("nb4_count", 32'(lg2.size()), 64);
      check("nb4_max_out", 32'(max_out[2]), 2);
      check("nb4_phase_viol", 32'(viol[2]), 0);
      check("nb2_phase_viol", 32'(viol[1]), 0);
      check("nb4_done_cnt", 32'(done_cnt[2]), 1);

      // NB=4 under manual word control: ready stall, inhibit, barrier
      man[2] = 1'b1;
      tr[2]  = 1'b0;
      lg2.delete();
      st[2] = 1'b1;
      @(negedge clk);
      st[2] = 1'b0;
      check("stall_valid0", 32'(tv[2]), 1);
      check("stall_desc0", 32'(dsc(2)), 0);
      for (int c = 0; c < 5; c++) begin
         inh[2] = ~inh[2];
         @(negedge clk);
         check($sformatf("stall_valid[%0d]", c), 32'(tv[2]), 1);
         check($sformatf("stall_desc[%0d]", c), 32'(dsc(2)), 0);
      end
      inh[2] = 1'b0;
      tr[2]  = 1'b1;
      @(negedge clk);
      tr[2]  = 1'b0;
      check("stall_accepted", 32'(lg2.size()), 1);
      check("self_drain_valid", 32'(tv[2]), 0);
      words(2, 16);
      @(negedge clk);
      check("row_first_valid", 32'(tv[2]), 1);
      check("row_first_desc", 32'(dsc(2)), 32'(8'b01_00_01_00));
      tr[2] = 1'b1;
      @(negedge clk);
      tr[2] = 1'b0;
      check("row_second_desc", 32'(dsc(2)), 32'(8'b01_00_10_00));
      words(2, 15);
      tr[2] = 1'b1; man_ov[2] = 1'b1; st[2] = 1'b1;
      @(negedge clk);
      tr[2] = 1'b0; man_ov[2] = 1'b0; st[2] = 1'b0;
      check("sim_acc_ret_valid", 32'(tv[2]), 1);
      check("sim_acc_ret_desc", 32'(dsc(2)), 32'(8'b01_00_11_00));
      check("midrun_start_busy", 32'(bsy[2]), 1);
      tr[2] = 1'b1;
      @(negedge clk);
      tr[2] = 1'b0;
      check("row_last_drain", 32'(tv[2]), 0);
      words(2, 16);
      @(negedge clk);
      check("barrier_hold_valid", 32'(tv[2]), 0);
      check("barrier_hold_phase", 32'(ph[2]), 32'(2'b01));
      words(2, 16);
      @(negedge clk);
      check("col_first_valid", 32'(tv[2]), 1);
      check("col_first_desc", 32'(dsc(2)), 32'(8'b10_01_00_00));

      // reset in the middle of phase 11 on NB=2, then replay
      tr[1] = 1'b1;
      st[1] = 1'b1;
      @(negedge clk);
      st[1] = 1'b0;
      ok = 1'b0;
      for (int g = 0; g < 3000 && !ok; g++) begin
         @(negedge clk);
         ok = (ph[1] == 2'b11);
      end
      check("reach_phase11", 32'(ok), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bsy[1]), 0);
      check("mid_rst_done", 32'(dn[1]), 0);
      check("mid_rst_valid", 32'(tv[1]), 0);
      check("mid_rst_desc", 32'(dsc(1)), 0);
      check("mid_rst_nb4_valid", 32'(tv[2]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      man[2] = 1'b0;
      @(negedge clk);
      st[1] = 1'b1;
      @(negedge clk);
      st[1] = 1'b0;
      check("replay_valid", 32'(tv[1]), 1);
      check("replay_desc", 32'(dsc(1)), 0);
      check("replay_busy", 32'(bsy[1]), 1);
      ok = 1'b0;
      for (int g = 0; g < 3000 && !ok; g++) begin
         @(negedge clk);
         ok = done_cnt[1] > 0 && !bsy[1];
      end
      check("replay_complete", 32'(ok), 1);
      check("replay_count", 32'(lg1.size()), 8);
      for (int n = 0; n < 8; n++)
         check($sformatf("replay_order[%0d]", n), 32'((n < lg1.size()) ? lg1[n] : 8'hxx), 32'(exp2[n]));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
